// File: rtl/debug_commit_trace_reader_pkg.sv
// Shared trace record layout and default sizing for the debug commit trace path.
package DebugTypes;

   localparam int TRACE_COMMIT_WIDTH   = 2;
   localparam int TRACE_PC_WIDTH       = 32;
   localparam int TRACE_FIFO_DEPTH     = 16;
   localparam int TRACE_SEQ_WIDTH      = 16;
   localparam int TRACE_DROP_CNT_WIDTH = 16;

   typedef logic [TRACE_PC_WIDTH-1:0] PC_Path;

   typedef struct packed {
      PC_Path                     pc;
      logic [TRACE_SEQ_WIDTH-1:0] seq;
      logic                       isRecover;
   } TraceRecord;

endpackage

// File: rtl/debug_commit_trace_reader_fifo.sv
// Trace record buffer: up to NWR writes per cycle into consecutive slots, one read.
module debug_trace_fifo #(
   parameter  int REC_W = 49,
   parameter  int DEPTH = 16,
   parameter  int NWR   = 3,
   localparam int AW    = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH + 1),
   localparam int PW    = $clog2(NWR + 1)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [PW-1:0]              wr_num_i,
   input  logic [NWR-1:0][REC_W-1:0]  wr_data_i,
   input  logic                       rd_en_i,
   output logic [REC_W-1:0]           rd_data_o,
   output logic [CNT_W-1:0]           count_o
);

   logic [REC_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             pop;

   // The caller guarantees wr_num_i never exceeds the free space.
   assign pop      = rd_en_i && (count_q != '0);
   assign wr_ptr_d = wr_ptr_q + AW'(wr_num_i);
   assign rd_ptr_d = rd_ptr_q + AW'(pop);
   assign count_d  = count_q + CNT_W'(wr_num_i) - CNT_W'(pop);

   always_ff @(posedge clk) begin
      for (int j = 0; j < NWR; j++) begin
         if (PW'(j) < wr_num_i) begin
            mem_q[wr_ptr_q + AW'(j)] <= wr_data_i[j];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign rd_data_o = mem_q[rd_ptr_q];
   assign count_o   = count_q;

endmodule

// File: rtl/debug_commit_trace_reader.sv
// Reads commit lanes and recovery events, packs them into numbered trace records and streams them to the host.
module debug_commit_trace_reader
   import DebugTypes::*;
#(
   parameter  int COMMIT_WIDTH   = TRACE_COMMIT_WIDTH,
   parameter  int PC_WIDTH       = TRACE_PC_WIDTH,
   parameter  int FIFO_DEPTH     = TRACE_FIFO_DEPTH,
   parameter  int SEQ_WIDTH      = TRACE_SEQ_WIDTH,
   parameter  int DROP_CNT_WIDTH = TRACE_DROP_CNT_WIDTH,
   localparam int CNT_W          = $clog2(FIFO_DEPTH + 1)
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           enable,
   input  logic [COMMIT_WIDTH-1:0]        cmValid,
   input  logic [COMMIT_WIDTH*PC_WIDTH-1:0] cmPC,
   input  logic                           recover,
   input  logic                           clearStats,
   output logic                           outValid,
   input  logic                           outReady,
   output logic [PC_WIDTH-1:0]            outPC,
   output logic [SEQ_WIDTH-1:0]           outSeq,
   output logic                           outRecover,
   output logic [CNT_W-1:0]               fifoCount,
   output logic [DROP_CNT_WIDTH-1:0]      dropCount,
   output logic                           overflow
);

   localparam int NREC  = COMMIT_WIDTH + 1;
   localparam int REC_W = PC_WIDTH + SEQ_WIDTH + 1;
   localparam int REQ_W = $clog2(NREC + 1);

   logic [NREC-1:0][REC_W-1:0]  wr_data;
   logic [REQ_W-1:0]            n_lanes, req, wr_num;
   logic [CNT_W-1:0]            count, free;
   logic                        fits, drop;
   logic [REC_W-1:0]            rd_data;

   logic [SEQ_WIDTH-1:0]        seq_q, seq_d;
   logic [DROP_CNT_WIDTH-1:0]   drop_q, drop_d, drop_base;
   logic [DROP_CNT_WIDTH:0]     drop_sum;
   logic                        ovf_q, ovf_d;

   // Compact valid lanes to the front; each record's seq is its rank among this cycle's commits.
   always_comb begin
      int idx;
      wr_data = '0;
      idx     = 0;
      for (int i = 0; i < COMMIT_WIDTH; i++) begin
         if (cmValid[i]) begin
            wr_data[idx] = {cmPC[i*PC_WIDTH +: PC_WIDTH], seq_q + SEQ_WIDTH'(idx), 1'b0};
            idx          = idx + 1;
         end
      end
      n_lanes = REQ_W'(idx);
      if (recover) begin
         wr_data[idx] = {{PC_WIDTH{1'b0}}, seq_q + SEQ_WIDTH'(idx), 1'b1};
      end
   end

   assign req    = enable ? (n_lanes + REQ_W'(recover)) : '0;
   // Free space comes from the registered count; a same-cycle pop is not credited.
   assign free   = CNT_W'(FIFO_DEPTH) - count;
   assign fits   = CNT_W'(req) <= free;
   assign drop   = enable && !fits;
   assign wr_num = (enable && fits) ? req : '0;

   assign seq_d  = enable ? seq_q + SEQ_WIDTH'(n_lanes) : seq_q;

   // A drop in the same cycle as clearStats restarts the count from this cycle's loss.
   assign drop_base = clearStats ? '0 : drop_q;
   assign drop_sum  = {1'b0, drop_base} + (DROP_CNT_WIDTH+1)'(req);
   assign drop_d    = !drop ? drop_base
                    : (drop_sum[DROP_CNT_WIDTH] ? '1 : drop_sum[DROP_CNT_WIDTH-1:0]);
   assign ovf_d     = drop | (ovf_q & ~clearStats);

   always_ff @(posedge clk) begin
      if (rst) begin
         seq_q  <= '0;
         drop_q <= '0;
         ovf_q  <= 1'b0;
      end else begin
         seq_q  <= seq_d;
         drop_q <= drop_d;
         ovf_q  <= ovf_d;
      end
   end

   debug_trace_fifo #(
      .REC_W (REC_W),
      .DEPTH (FIFO_DEPTH),
      .NWR   (NREC)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .wr_num_i  (wr_num),
      .wr_data_i (wr_data),
      .rd_en_i   (outReady),
      .rd_data_o (rd_data),
      .count_o   (count)
   );

   assign outValid                       = (count != '0);
   assign {outPC, outSeq, outRecover}    = rd_data;
   assign fifoCount                      = count;
   assign dropCount                      = drop_q;
   assign overflow                       = ovf_q;

endmodule

// File: tb/tb_debug_commit_trace_reader.sv
// Scoreboard bench for the commit trace reader: a cycle model predicts records, counts and statistics.
module tb_debug_commit_trace_reader;
   import DebugTypes::*;

   localparam int CW = 2;
   localparam int PW = 32;
   localparam int FD = 16;
   localparam int SW = 16;
   localparam int DW = 16;

   logic              clk = 1'b0;
   logic              rst, enable, recover, clearStats, outReady;
   logic [CW-1:0]     cmValid;
   logic [CW*PW-1:0]  cmPC;
   logic              outValid, outRecover, overflow;
   logic [PW-1:0]     outPC;
   logic [SW-1:0]     outSeq;
   logic [4:0]        fifoCount;
   logic [DW-1:0]     dropCount;

   debug_commit_trace_reader dut (
      .clk(clk), .rst(rst), .enable(enable), .cmValid(cmValid), .cmPC(cmPC),
      .recover(recover), .clearStats(clearStats), .outValid(outValid),
      .outReady(outReady), .outPC(outPC), .outSeq(outSeq), .outRecover(outRecover),
      .fifoCount(fifoCount), .dropCount(dropCount), .overflow(overflow)
   );

   always #5 clk = ~clk;

   TraceRecord   sb[$];
   int           mdl_cnt;
   logic [SW-1:0] mdl_seq;
   int           mdl_drop;
   logic         mdl_ovf;
   int           n_chk = 0;
   int           n_fail = 0;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Drive one cycle at the falling edge, check pre-edge state, then advance the model.
   task automatic cyc(input logic [1:0] v, input logic [31:0] pc0, input logic [31:0] pc1,
                      input logic rec, input logic rdy,
                      input logic en = 1'b1, input logic clr = 1'b0);
      TraceRecord r;
      int pre, nv, req, pushed, popped, sum;
      logic [SW-1:0] s;
      @(negedge clk);
      rst = 1'b0; cmValid = v; cmPC = {pc1, pc0}; recover = rec;
      outReady = rdy; enable = en; clearStats = clr;
      #1;
      pre = mdl_cnt;
      chk("outValid", 64'(outValid), 64'(pre != 0));
      chk("fifoCount", 64'(fifoCount), 64'(pre));
      chk("dropCount", 64'(dropCount), 64'(mdl_drop));
      chk("overflow", 64'(overflow), 64'(mdl_ovf));
      popped = 0;
      if (pre != 0 && rdy) begin
         r = sb.pop_front();
         chk("outPC", 64'(outPC), 64'(r.pc));
         chk("outSeq", 64'(outSeq), 64'(r.seq));
         chk("outRecover", 64'(outRecover), 64'(r.isRecover));
         popped = 1;
      end
      nv = int'(v[0]) + int'(v[1]);
      req = en ? nv + int'(rec) : 0;
      pushed = 0;
      if (en) begin
         if (req <= FD - pre) begin
            s = mdl_seq;
            if (v[0]) begin r.pc = pc0; r.seq = s; r.isRecover = 1'b0; sb.push_back(r); s++; end
            if (v[1]) begin r.pc = pc1; r.seq = s; r.isRecover = 1'b0; sb.push_back(r); s++; end
            if (rec)  begin r.pc = '0;  r.seq = s; r.isRecover = 1'b1; sb.push_back(r); end
            pushed = req;
            if (clr) begin mdl_drop = 0; mdl_ovf = 1'b0; end
         end else begin
            sum = (clr ? 0 : mdl_drop) + req;
            mdl_drop = (sum > 16'hFFFF) ? 16'hFFFF : sum;
            mdl_ovf = 1'b1;
         end
         mdl_seq = mdl_seq + SW'(nv);
      end else if (clr) begin
         mdl_drop = 0; mdl_ovf = 1'b0;
      end
      mdl_cnt = pre - popped + pushed;
   endtask

   // Reset with live commit traffic present: reset must override it.
   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; enable = 1'b1; cmValid = 2'b11; cmPC = {32'hDEAD, 32'hBEEF};
      recover = 1'b1; outReady = 1'b0; clearStats = 1'b0;
      sb.delete();
      mdl_cnt = 0; mdl_seq = '0; mdl_drop = 0; mdl_ovf = 1'b0;
   endtask

   initial begin
      rst = 1'b1; enable = 1'b0; cmValid = '0; cmPC = '0; recover = 1'b0;
      outReady = 1'b0; clearStats = 1'b0;
      do_reset();

      // Two lanes in one cycle drain in lane order.
      cyc(2'b11, 32'h100, 32'h104, 1'b0, 1'b1);
      repeat (3) cyc(2'b00, 0, 0, 1'b0, 1'b1);

      // Upper lane plus recovery marker.
      cyc(2'b10, 0, 32'h200, 1'b1, 1'b1);
      cyc(2'b01, 32'h300, 0, 1'b0, 1'b1);
      repeat (4) cyc(2'b00, 0, 0, 1'b0, 1'b1);

      // Fill to full, ninth cycle drops, then seq 18 follows seqs 0..15.
      do_reset();
      for (int i = 0; i < 8; i++) cyc(2'b11, 32'h1000 + 8*i, 32'h1004 + 8*i, 1'b0, 1'b0);
      cyc(2'b11, 32'h2000, 32'h2004, 1'b0, 1'b0);
      #5;
      chk("drop_after_full", 64'(dropCount), 64'd2);
      chk("ovf_after_full", 64'(overflow), 64'd1);
      cyc(2'b00, 0, 0, 1'b0, 1'b1);
      cyc(2'b01, 32'h3000, 0, 1'b0, 1'b1);
      repeat (17) cyc(2'b00, 0, 0, 1'b0, 1'b1);

      // Count 15, req 2, pop in same cycle: dropped, count falls to 14.
      do_reset();
      for (int i = 0; i < 8; i++) cyc(2'b11, 32'h40 + 8*i, 32'h44 + 8*i, 1'b0, 1'b0);
      cyc(2'b00, 0, 0, 1'b0, 1'b1);
      cyc(2'b11, 32'h500, 32'h504, 1'b0, 1'b1);
      #5;
      chk("count_after_drop", 64'(fifoCount), 64'd14);

      // Mid-drain reset empties the FIFO.
      do_reset();
      cyc(2'b00, 0, 0, 1'b0, 1'b1);

      // clearStats concurrent with a 3-record drop, then alone.
      for (int i = 0; i < 8; i++) cyc(2'b11, 32'h60 + 8*i, 32'h64 + 8*i, 1'b0, 1'b0);
      cyc(2'b11, 32'h700, 32'h704, 1'b1, 1'b0, 1'b1, 1'b1);
      #5;
      chk("clr_with_drop_cnt", 64'(dropCount), 64'd3);
      chk("clr_with_drop_ovf", 64'(overflow), 64'd1);
      cyc(2'b00, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1);
      #5;
      chk("clr_alone_cnt", 64'(dropCount), 64'd0);
      chk("clr_alone_ovf", 64'(overflow), 64'd0);

      // enable=0 adds nothing while draining.
      cyc(2'b11, 32'h800, 32'h804, 1'b1, 1'b1, 1'b0);
      repeat (16) cyc(2'b00, 0, 0, 1'b0, 1'b1, 1'b0);

      // Saturate dropCount while walking seqCnt to 0xFFFF, then check seq wrap.
      do_reset();
      for (int i = 0; i < 8; i++) cyc(2'b11, 32'h80 + 8*i, 32'h84 + 8*i, 1'b0, 1'b0);
      while (mdl_seq != 16'hFFFF)
         cyc((mdl_seq == 16'hFFFE) ? 2'b01 : 2'b11, 32'h900, 32'h904, 1'b1, 1'b0);
      cyc(2'b00, 0, 0, 1'b1, 1'b0);
      #5;
      chk("drop_saturated", 64'(dropCount), 64'hFFFF);
      repeat (16) cyc(2'b00, 0, 0, 1'b0, 1'b1);
      cyc(2'b01, 32'hA00, 0, 1'b0, 1'b1);
      cyc(2'b01, 32'hA04, 0, 1'b0, 1'b1);
      #5;
      chk("wrap_head_seq", 64'(outSeq), 64'h0000);
      repeat (3) cyc(2'b00, 0, 0, 1'b0, 1'b1);

      chk("sb_empty", 64'(sb.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
